// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - field layout and class encoding of the decoded instruction bundle
package sched_pkg;
    localparam int INSTR_W     = 64;
    localparam int NREGS       = 32;

    localparam int RD_LSB      = 0;
    localparam int RS1_LSB     = 5;
    localparam int RS2_LSB     = 10;
    localparam int RD_WE_BIT   = 15;
    localparam int USE_RS1_BIT = 16;
    localparam int USE_RS2_BIT = 17;
    localparam int CLS_LSB     = 18;
    localparam int FIELDS_W    = 20;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_MEM = 2'd1,
        CLS_BR  = 2'd2,
        CLS_MUL = 2'd3
    } cls_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rd_we;
        logic       use_rs1;
        logic       use_rs2;
        cls_e       cls;
    } fields_t;

    function automatic fields_t decode(input logic [FIELDS_W-1:0] b);
        fields_t f;
        f.rd      = b[RD_LSB +: 5];
        f.rs1     = b[RS1_LSB +: 5];
        f.rs2     = b[RS2_LSB +: 5];
        f.rd_we   = b[RD_WE_BIT];
        f.use_rs1 = b[USE_RS1_BIT];
        f.use_rs2 = b[USE_RS2_BIT];
        f.cls     = cls_e'(b[CLS_LSB +: 2]);
        return f;
    endfunction
endpackage

// File: rtl/sched_scoreboard.sv
// rtl/sched_scoreboard.sv - pending-write vector with two set ports, two clear ports and six lookups
module sched_scoreboard #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        set0_en_i,
    input  logic [4:0]  set0_idx_i,
    input  logic        set1_en_i,
    input  logic [4:0]  set1_idx_i,
    input  logic        clr0_en_i,
    input  logic [4:0]  clr0_idx_i,
    input  logic        clr1_en_i,
    input  logic [4:0]  clr1_idx_i,
    input  logic [29:0] rd_idx_i,
    output logic [5:0]  pend_o
);
    import sched_pkg::*;

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Sets are applied after clears so an issue colliding with a writeback stays pending.
    always_comb begin
        pend_d = pend_q;
        if (clr0_en_i) pend_d[clr0_idx_i] = 1'b0;
        if (clr1_en_i) pend_d[clr1_idx_i] = 1'b0;
        if (set0_en_i) pend_d[set0_idx_i] = 1'b1;
        if (set1_en_i) pend_d[set1_idx_i] = 1'b1;
        pend_d[0] = 1'b0;
        if (flush_i) pend_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        pend_o = '0;
        for (int i = 0; i < 6; i++) begin
            pend_o[i] = pend_q[rd_idx_i[5*i +: 5]];
        end
    end
endmodule

// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - in-order dual-issue from the FIFO head pair into two pipe issue registers
module dual_issue_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int INSTR_W    = sched_pkg::INSTR_W,
    parameter int NREGS      = sched_pkg::NREGS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] fifo_out1_i,
    input  logic [INSTR_W-1:0] fifo_out2_i,
    input  logic               fifo_valid1_i,
    input  logic               fifo_valid2_i,
    output logic [1:0]         deq_cnt_o,
    output logic               deq_en_o,
    output logic [INSTR_W-1:0] ex0_instr_o,
    output logic               ex0_valid_o,
    input  logic               ex0_ready_i,
    output logic [INSTR_W-1:0] ex1_instr_o,
    output logic               ex1_valid_o,
    input  logic               ex1_ready_i,
    input  logic               wb0_en_i,
    input  logic [4:0]         wb0_rd_i,
    input  logic               wb1_en_i,
    input  logic [4:0]         wb1_rd_i,
    output logic [15:0]        stall_cnt_o
);
    import sched_pkg::*;

    fields_t            fa;
    fields_t            fb;
    logic [5:0]         pend_hit;
    logic               a_haz, b_haz, a_writes, b_writes, pair_dep;
    logic               ex0_free, ex1_free, a_issue, b_issue;

    logic [INSTR_W-1:0] ex0_instr_q, ex0_instr_d, ex1_instr_q, ex1_instr_d;
    logic               ex0_valid_q, ex0_valid_d, ex1_valid_q, ex1_valid_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;

    assign fa = decode(fifo_out1_i[FIELDS_W-1:0]);
    assign fb = decode(fifo_out2_i[FIELDS_W-1:0]);

    sched_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .set0_en_i  (a_issue && a_writes),
        .set0_idx_i (fa.rd),
        .set1_en_i  (b_issue && b_writes),
        .set1_idx_i (fb.rd),
        .clr0_en_i  (wb0_en_i),
        .clr0_idx_i (wb0_rd_i),
        .clr1_en_i  (wb1_en_i),
        .clr1_idx_i (wb1_rd_i),
        .rd_idx_i   ({fb.rd, fb.rs2, fb.rs1, fa.rd, fa.rs2, fa.rs1}),
        .pend_o     (pend_hit)
    );

    assign a_haz    = (fa.use_rs1 && pend_hit[0]) || (fa.use_rs2 && pend_hit[1]) || (fa.rd_we && pend_hit[2]);
    assign b_haz    = (fb.use_rs1 && pend_hit[3]) || (fb.use_rs2 && pend_hit[4]) || (fb.rd_we && pend_hit[5]);
    assign a_writes = fa.rd_we && (fa.rd != 5'd0);
    assign b_writes = fb.rd_we && (fb.rd != 5'd0);

    // B must not read or overwrite what A produces in the same pair.
    assign pair_dep = a_writes && ((fb.use_rs1 && (fb.rs1 == fa.rd)) ||
                                   (fb.use_rs2 && (fb.rs2 == fa.rd)) ||
                                   (fb.rd_we   && (fb.rd  == fa.rd)));

    assign ex0_free = !ex0_valid_q || ex0_ready_i;
    assign ex1_free = !ex1_valid_q || ex1_ready_i;

    assign a_issue  = !rst && !flush_i && fifo_valid1_i && !a_haz && ex0_free;
    assign b_issue  = a_issue && fifo_valid2_i && (fb.cls == CLS_ALU) && (fa.cls != CLS_BR) &&
                      !b_haz && !pair_dep && ex1_free;

    assign deq_cnt_o = 2'(a_issue) + 2'(b_issue);
    assign deq_en_o  = |deq_cnt_o;

    always_comb begin
        ex0_valid_d = ex0_valid_q;
        ex0_instr_d = ex0_instr_q;
        ex1_valid_d = ex1_valid_q;
        ex1_instr_d = ex1_instr_q;
        if (flush_i) begin
            ex0_valid_d = 1'b0;
            ex1_valid_d = 1'b0;
        end else begin
            if (a_issue) begin
                ex0_valid_d = 1'b1;
                ex0_instr_d = fifo_out1_i;
            end else if (ex0_ready_i) begin
                ex0_valid_d = 1'b0;
            end
            if (b_issue) begin
                ex1_valid_d = 1'b1;
                ex1_instr_d = fifo_out2_i;
            end else if (ex1_ready_i) begin
                ex1_valid_d = 1'b0;
            end
        end
        stall_cnt_d = stall_cnt_q;
        if (fifo_valid1_i && (deq_cnt_o == 2'd0) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex0_valid_q <= 1'b0;
            ex0_instr_q <= '0;
            ex1_valid_q <= 1'b0;
            ex1_instr_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex0_valid_q <= ex0_valid_d;
            ex0_instr_q <= ex0_instr_d;
            ex1_valid_q <= ex1_valid_d;
            ex1_instr_q <= ex1_instr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex0_valid_o = ex0_valid_q;
    assign ex0_instr_o = ex0_instr_q;
    assign ex1_valid_o = ex1_valid_q;
    assign ex1_instr_o = ex1_instr_q;
    assign stall_cnt_o = stall_cnt_q;

    a_pop_bound: assert property (@(posedge clk) disable iff (rst)
        (!b_issue || a_issue) && (int'(deq_cnt_o) <= FIFO_DEPTH));
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - vector table, corner sequences and reference-model random test for dual_issue_scheduler
module tb_dual_issue_scheduler;
    logic        clk = 1'b0;
    logic        rst, flush_i;
    logic [63:0] fifo_out1_i, fifo_out2_i;
    logic        fifo_valid1_i, fifo_valid2_i;
    logic [1:0]  deq_cnt_o;
    logic        deq_en_o;
    logic [63:0] ex0_instr_o, ex1_instr_o;
    logic        ex0_valid_o, ex1_valid_o, ex0_ready_i, ex1_ready_i;
    logic        wb0_en_i, wb1_en_i;
    logic [4:0]  wb0_rd_i, wb1_rd_i;
    logic [15:0] stall_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dual_issue_scheduler dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .fifo_out1_i(fifo_out1_i), .fifo_out2_i(fifo_out2_i),
        .fifo_valid1_i(fifo_valid1_i), .fifo_valid2_i(fifo_valid2_i),
        .deq_cnt_o(deq_cnt_o), .deq_en_o(deq_en_o),
        .ex0_instr_o(ex0_instr_o), .ex0_valid_o(ex0_valid_o), .ex0_ready_i(ex0_ready_i),
        .ex1_instr_o(ex1_instr_o), .ex1_valid_o(ex1_valid_o), .ex1_ready_i(ex1_ready_i),
        .wb0_en_i(wb0_en_i), .wb0_rd_i(wb0_rd_i), .wb1_en_i(wb1_en_i), .wb1_rd_i(wb1_rd_i),
        .stall_cnt_o(stall_cnt_o)
    );

    localparam logic [1:0] ALU = 2'd0, MEM = 2'd1, BR = 2'd2, MUL = 2'd3;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        v1;
        logic        v2;
        logic [1:0]  exp_deq;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [1:0] cls, input logic [4:0] rd, input logic we,
                                       input logic [4:0] rs1, input logic u1,
                                       input logic [4:0] rs2, input logic u2, input logic [31:0] tag);
        return {tag, 12'h0, cls, u2, u1, we, rs2, rs1, rd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i = 1'b0; fifo_valid1_i = 1'b0; fifo_valid2_i = 1'b0;
        fifo_out1_i = '0; fifo_out2_i = '0;
        ex0_ready_i = 1'b1; ex1_ready_i = 1'b1;
        wb0_en_i = 1'b0; wb1_en_i = 1'b0; wb0_rd_i = '0; wb1_rd_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reference model: architectural pending set plus the two pipe slots.
    logic [31:0] m_pend;
    logic        m_v0, m_v1;
    logic [63:0] m_i0, m_i1;
    int          m_stall;

    function automatic bit blocked(input logic [63:0] x);
        return (x[16] && m_pend[x[9:5]]) || (x[17] && m_pend[x[14:10]]) || (x[15] && m_pend[x[4:0]]);
    endfunction

    function automatic bit produces(input logic [63:0] x);
        return x[15] && (x[4:0] != 5'd0);
    endfunction

    function automatic bit touches(input logic [63:0] x, input logic [4:0] r);
        return (x[16] && x[9:5] == r) || (x[17] && x[14:10] == r) || (x[15] && x[4:0] == r);
    endfunction

    function automatic int model_issue();
        if (rst || flush_i) return 0;
        if (!fifo_valid1_i || blocked(fifo_out1_i) || (m_v0 && !ex0_ready_i)) return 0;
        if (fifo_valid2_i && fifo_out2_i[19:18] == ALU && fifo_out1_i[19:18] != BR &&
            !blocked(fifo_out2_i) && !(m_v1 && !ex1_ready_i) &&
            !(produces(fifo_out1_i) && touches(fifo_out2_i, fifo_out1_i[4:0])))
            return 2;
        return 1;
    endfunction

    task automatic model_edge(input int n);
        if (rst) begin
            m_pend = '0; m_v0 = 0; m_v1 = 0; m_i0 = '0; m_i1 = '0; m_stall = 0;
            return;
        end
        if (fifo_valid1_i && n == 0 && m_stall < 65535) m_stall++;
        if (flush_i) begin
            m_v0 = 0; m_v1 = 0; m_pend = '0;
            return;
        end
        if (wb0_en_i) m_pend[wb0_rd_i] = 1'b0;
        if (wb1_en_i) m_pend[wb1_rd_i] = 1'b0;
        if (n >= 1) begin
            m_v0 = 1; m_i0 = fifo_out1_i;
            if (produces(fifo_out1_i)) m_pend[fifo_out1_i[4:0]] = 1'b1;
        end else if (ex0_ready_i) m_v0 = 0;
        if (n == 2) begin
            m_v1 = 1; m_i1 = fifo_out2_i;
            if (produces(fifo_out2_i)) m_pend[fifo_out2_i[4:0]] = 1'b1;
        end else if (ex1_ready_i) m_v1 = 0;
        m_pend[0] = 1'b0;
    endtask

    function automatic logic [63:0] rnd_instr();
        logic [1:0] cls;
        cls = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : ALU;
        return mk(cls, 5'($urandom_range(7)), 1'($urandom_range(1)),
                  5'($urandom_range(7)), 1'($urandom_range(1)),
                  5'($urandom_range(7)), 1'($urandom_range(1)), $urandom);
    endfunction

    logic [63:0] ia, ib, ic;
    int          n;

    initial begin
        vecs[0]  = '{mk(ALU,3,1,0,0,0,0,32'h1),  mk(ALU,4,1,0,0,0,0,32'h2),  1'b1, 1'b1, 2'd2};
        vecs[1]  = '{mk(ALU,5,1,0,0,0,0,32'h3),  mk(ALU,6,1,5,1,0,0,32'h4),  1'b1, 1'b1, 2'd1};
        vecs[2]  = '{mk(ALU,5,1,0,0,0,0,32'h5),  mk(ALU,5,1,0,0,0,0,32'h6),  1'b1, 1'b1, 2'd1};
        vecs[3]  = '{mk(BR,0,0,1,1,2,1,32'h7),   mk(ALU,4,1,0,0,0,0,32'h8),  1'b1, 1'b1, 2'd1};
        vecs[4]  = '{mk(ALU,3,1,0,0,0,0,32'h9),  mk(MEM,4,1,1,1,0,0,32'ha),  1'b1, 1'b1, 2'd1};
        vecs[5]  = '{mk(MUL,2,1,0,0,0,0,32'hb),  mk(ALU,3,1,0,0,0,0,32'hc),  1'b1, 1'b1, 2'd2};
        vecs[6]  = '{mk(ALU,3,1,0,0,0,0,32'hd),  mk(ALU,4,1,0,0,0,0,32'he),  1'b1, 1'b0, 2'd1};
        vecs[7]  = '{mk(ALU,3,1,0,0,0,0,32'hf),  mk(ALU,4,1,0,0,0,0,32'h10), 1'b0, 1'b1, 2'd0};
        vecs[8]  = '{mk(ALU,6,1,0,0,0,0,32'h11), mk(ALU,7,1,0,0,6,1,32'h12), 1'b1, 1'b1, 2'd1};
        vecs[9]  = '{mk(ALU,6,1,0,0,0,0,32'h13), mk(ALU,7,1,6,0,0,0,32'h14), 1'b1, 1'b1, 2'd2};
        vecs[10] = '{mk(ALU,0,1,0,0,0,0,32'h15), mk(ALU,0,1,0,1,0,0,32'h16), 1'b1, 1'b1, 2'd2};
        vecs[11] = '{mk(ALU,6,0,0,0,0,0,32'h17), mk(ALU,7,1,6,1,0,0,32'h18), 1'b1, 1'b1, 2'd2};

        // Reset state, and no pop while rst is held.
        idle_inputs();
        rst = 1'b1;
        fifo_out1_i = vecs[0].a; fifo_valid1_i = 1'b1;
        #1;
        chk("rst_deq", 64'(deq_cnt_o), 64'd0);
        tick();
        chk("rst_ex0_valid", 64'(ex0_valid_o), 64'd0);
        chk("rst_ex1_valid", 64'(ex1_valid_o), 64'd0);
        chk("rst_ex0_instr", ex0_instr_o, 64'd0);
        chk("rst_ex1_instr", ex1_instr_o, 64'd0);
        chk("rst_stall", 64'(stall_cnt_o), 64'd0);
        chk("rst_pend", 64'(dut.u_sb.pend_q), 64'd0);

        for (int i = 0; i < 12; i++) begin
            do_reset();
            fifo_out1_i = vecs[i].a; fifo_out2_i = vecs[i].b;
            fifo_valid1_i = vecs[i].v1; fifo_valid2_i = vecs[i].v2;
            #1;
            chk($sformatf("vec%0d_deq", i), 64'(deq_cnt_o), 64'(vecs[i].exp_deq));
            chk($sformatf("vec%0d_deq_en", i), 64'(deq_en_o), 64'(vecs[i].exp_deq != 0));
            tick();
            chk($sformatf("vec%0d_ex0_valid", i), 64'(ex0_valid_o), 64'(vecs[i].exp_deq >= 1));
            chk($sformatf("vec%0d_ex1_valid", i), 64'(ex1_valid_o), 64'(vecs[i].exp_deq == 2));
            chk($sformatf("vec%0d_ex0_instr", i), ex0_instr_o, (vecs[i].exp_deq >= 1) ? vecs[i].a : 64'd0);
            chk($sformatf("vec%0d_ex1_instr", i), ex1_instr_o, (vecs[i].exp_deq == 2) ? vecs[i].b : 64'd0);
        end

        // Independent pair marks both destinations pending.
        do_reset();
        fifo_out1_i = mk(ALU,3,1,0,0,0,0,32'h21); fifo_out2_i = mk(ALU,4,1,0,0,0,0,32'h22);
        fifo_valid1_i = 1; fifo_valid2_i = 1;
        tick();
        chk("pair_pend3", 64'(dut.u_sb.pend_q[3]), 64'd1);
        chk("pair_pend4", 64'(dut.u_sb.pend_q[4]), 64'd1);
        fifo_out1_i = mk(ALU,8,1,4,1,0,0,32'h23); fifo_valid2_i = 0;
        #1;
        chk("pair_dep_blocked", 64'(deq_cnt_o), 64'd0);

        // Intra-pair RAW: B waits for the producer writeback, no same-cycle bypass.
        do_reset();
        ia = mk(ALU,5,1,0,0,0,0,32'h31); ib = mk(ALU,6,1,5,1,0,0,32'h32);
        fifo_out1_i = ia; fifo_out2_i = ib; fifo_valid1_i = 1; fifo_valid2_i = 1;
        #1;
        chk("raw_deq_pair", 64'(deq_cnt_o), 64'd1);
        tick();
        fifo_out1_i = ib; fifo_valid2_i = 0;
        #1;
        chk("raw_wait0", 64'(deq_cnt_o), 64'd0);
        tick();
        chk("raw_wait1", 64'(deq_cnt_o), 64'd0);
        wb0_en_i = 1; wb0_rd_i = 5'd5;
        #1;
        chk("raw_no_bypass", 64'(deq_cnt_o), 64'd0);
        tick();
        wb0_en_i = 0;
        #1;
        chk("raw_after_wb", 64'(deq_cnt_o), 64'd1);
        tick();
        chk("raw_ex0_valid", 64'(ex0_valid_o), 64'd1);
        chk("raw_ex0_instr", ex0_instr_o, ib);

        // Backpressure on pipe 0.
        do_reset();
        ia = mk(ALU,0,0,0,0,0,0,32'h41);
        fifo_out1_i = ia; fifo_valid1_i = 1;
        tick();
        ex0_ready_i = 0; fifo_out1_i = mk(ALU,0,0,0,0,0,0,32'h42);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_deq", 64'(deq_cnt_o), 64'd0);
            tick();
            chk("bp_ex0_hold", ex0_instr_o, ia);
            chk("bp_ex0_valid", 64'(ex0_valid_o), 64'd1);
            chk("bp_stall", 64'(stall_cnt_o), 64'(k + 1));
        end

        // Set/clear collision, then flush.
        do_reset();
        fifo_out1_i = mk(ALU,7,1,0,0,0,0,32'h51); fifo_valid1_i = 1;
        wb0_en_i = 1; wb0_rd_i = 5'd7;
        tick();
        wb0_en_i = 0;
        chk("coll_pend7", 64'(dut.u_sb.pend_q[7]), 64'd1);
        ic = mk(ALU,9,1,7,1,0,0,32'h52);
        fifo_out1_i = ic;
        #1;
        chk("coll_dep_blocked", 64'(deq_cnt_o), 64'd0);
        flush_i = 1;
        #1;
        chk("flush_deq", 64'(deq_cnt_o), 64'd0);
        tick();
        flush_i = 0;
        chk("flush_ex0_valid", 64'(ex0_valid_o), 64'd0);
        chk("flush_ex1_valid", 64'(ex1_valid_o), 64'd0);
        chk("flush_pend", 64'(dut.u_sb.pend_q), 64'd0);
        #1;
        chk("flush_dep_issue", 64'(deq_cnt_o), 64'd1);
        tick();
        chk("flush_dep_ex0", ex0_instr_o, ic);

        // Stall counter saturation, then reset mid-issue.
        do_reset();
        fifo_out1_i = mk(ALU,0,0,0,0,0,0,32'h61); fifo_valid1_i = 1;
        tick();
        ex0_ready_i = 0;
        repeat (65540) @(posedge clk);
        #1;
        chk("stall_sat", 64'(stall_cnt_o), 64'hFFFF);
        ex0_ready_i = 1;
        fifo_out2_i = mk(ALU,4,1,0,0,0,0,32'h62); fifo_valid2_i = 1;
        #1;
        chk("pre_rst_deq", 64'(deq_cnt_o), 64'd2);
        rst = 1;
        #1;
        chk("rst_mid_deq", 64'(deq_cnt_o), 64'd0);
        tick();
        rst = 0;
        chk("rst_mid_ex0_valid", 64'(ex0_valid_o), 64'd0);
        chk("rst_mid_ex1_valid", 64'(ex1_valid_o), 64'd0);
        chk("rst_mid_ex0_instr", ex0_instr_o, 64'd0);
        chk("rst_mid_ex1_instr", ex1_instr_o, 64'd0);
        chk("rst_mid_stall", 64'(stall_cnt_o), 64'd0);

        // Randomized traffic against the reference model.
        do_reset();
        m_pend = '0; m_v0 = 0; m_v1 = 0; m_i0 = '0; m_i1 = '0; m_stall = 0;
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(199) == 0);
            flush_i       = ($urandom_range(39) == 0);
            fifo_valid1_i = ($urandom_range(99) < 75);
            fifo_valid2_i = ($urandom_range(99) < 70);
            fifo_out1_i   = rnd_instr();
            fifo_out2_i   = rnd_instr();
            ex0_ready_i   = ($urandom_range(99) < 70);
            ex1_ready_i   = ($urandom_range(99) < 70);
            wb0_en_i      = ($urandom_range(99) < 30);
            wb0_rd_i      = 5'($urandom_range(7));
            wb1_en_i      = ($urandom_range(99) < 30);
            wb1_rd_i      = 5'($urandom_range(7));
            #1;
            n = model_issue();
            chk("rnd_deq", 64'(deq_cnt_o), 64'(n));
            chk("rnd_deq_en", 64'(deq_en_o), 64'(n != 0));
            @(posedge clk);
            model_edge(n);
            #1;
            chk("rnd_ex0_valid", 64'(ex0_valid_o), 64'(m_v0));
            chk("rnd_ex0_instr", ex0_instr_o, m_i0);
            chk("rnd_ex1_valid", 64'(ex1_valid_o), 64'(m_v1));
            chk("rnd_ex1_instr", ex1_instr_o, m_i1);
            chk("rnd_stall", 64'(stall_cnt_o), 64'(m_stall));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dual_issue_scheduler.md
# dual_issue_scheduler

In-order dual-issue scheduler directly downstream of the instruction FIFO. Each cycle it inspects the FIFO's two head entries and checks them against a register scoreboard, a pairing rule and execution-pipe backpressure. It issues 0, 1 or 2 instructions into registered issue slots for execution pipes 0 and 1, and reports back to the FIFO how many entries to pop.

## Interface
- `FIFO_DEPTH`, 8: depth of the upstream FIFO; informational, used for assertions only.
- `INSTR_W`, 64: decoded instruction bundle width.
- `NREGS`, 32: architectural registers tracked by the scoreboard; x0 is never tracked.
- `clk` in 1: clock.
- `rst` in 1: reset. Reset is synchronous and active-high.
- `flush_i` in 1: squash issue slots and clear the scoreboard.
- `fifo_out1_i` in INSTR_W: FIFO head entry (slot A).
- `fifo_out2_i` in INSTR_W: FIFO head+1 entry (slot B).
- `fifo_valid1_i` in 1: slot A valid.
- `fifo_valid2_i` in 1: slot B valid.
- `deq_cnt_o` out 2: entries the FIFO pops at this edge (0, 1 or 2).
- `deq_en_o` out 1: equals `|deq_cnt_o`.
- `ex0_instr_o` out INSTR_W: pipe 0 issue register.
- `ex0_valid_o` out 1: pipe 0 valid.
- `ex0_ready_i` in 1: pipe 0 accepts.
- `ex1_instr_o` out INSTR_W: pipe 1 issue register.
- `ex1_valid_o` out 1: pipe 1 valid.
- `ex1_ready_i` in 1: pipe 1 accepts.
- `wb0_en_i`, `wb1_en_i` in 1: writeback ports clear a scoreboard bit.
- `wb0_rd_i`, `wb1_rd_i` in 5: register being written back.
- `stall_cnt_o` out 16: saturating count of cycles with `fifo_valid1_i` high and `deq_cnt_o` equal to 0.

## Operation
- **Bundle fields:**
  - rd[4:0], rs1[9:5], rs2[14:10].
  - rd_we[15], use_rs1[16], use_rs2[17].
  - cls[19:18]: 0=ALU, 1=MEM, 2=BR, 3=MUL.
  - Remaining bits pass through untouched.
- **Scoreboard:** NREGS-bit pending vector.
  - Set at the edge an instruction with rd_we=1 and rd≠0 is loaded into an issue register.
  - Cleared at the edge of a writeback on `wbN_en_i`.
  - Bit 0 is constant 0.
- **Hazard:** an instruction is blocked if any of these pending bits is set: pend[rs1] with use_rs1, pend[rs2] with use_rs2, or pend[rd] with rd_we (WAW).
- **Slot A issues to pipe 0** when all hold:
  - `fifo_valid1_i`;
  - no hazard;
  - pipe 0 register is free (`!ex0_valid_o` or `ex0_ready_i`).
  - Any class may issue to pipe 0.
- **Slot B issues to pipe 1** when all hold:
  - slot A issues and `fifo_valid2_i`;
  - B.cls is ALU and A.cls is not BR;
  - B has no hazard;
  - no intra-pair RAW or WAW against A.rd (when A.rd_we and A.rd≠0);
  - pipe 1 register is free.
- `deq_cnt_o` = A_issue + B_issue. Slot B never issues without slot A, which keeps order.
- An issue register not loaded and not accepted holds its value. If accepted and not reloaded, its valid clears.
- **Flush:** takes priority over issue.
  - `ex0_valid_o`, `ex1_valid_o` and the entire scoreboard are cleared.
  - `deq_cnt_o` is 0 that cycle.
  - Writebacks during flush are ignored.
  - Flush is asserted only once the execution pipes are squashed.
- `stall_cnt_o` saturates at 0xFFFF. It is not cleared by flush.

## Timing
- Issue decision and `deq_cnt_o` are combinational from the FIFO outputs, scoreboard, ready signals and current issue registers in the same cycle.
- Issue registers and scoreboard update at the same edge as the FIFO pop; 1-cycle latency from FIFO head to `exN_valid_o`.
- A writeback clear at edge N makes the register issuable in cycle N+1. There is no same-cycle bypass.
- When set and clear hit the same register at one edge, set wins.
- A dependent instruction stalls until the producer's writeback edge.
- **Reset:** all of the following are 0: `ex0/1_valid_o`, `ex0/1_instr_o`, scoreboard, `stall_cnt_o`, `deq_cnt_o`.
- Reset mid-operation discards issue-register contents without handshake.
- Rst outranks flush.

## Structure
- **`sched_pkg`:** field offsets, cls encoding constants, NREGS, INSTR_W.
- **`sched_scoreboard` sub-module:** pending vector.
  - 2 set ports, 2 clear ports, flush.
  - Combinational lookup for 6 read indices per cycle.
- Top level holds the pairing logic, issue registers and stall counter.

## Test plan
- **Independent pair:** A = ALU rd=3, B = ALU rd=4 with no sources, both readies high → `deq_cnt_o`=2; next cycle both valids=1; pend[3] and pend[4] set.
- **Intra-pair RAW:** A writes rd=5, B uses rs1=5 → `deq_cnt_o`=1. B re-presents as the new head and issues to pipe 0 only after `wb0_rd_i`=5 is seen, one cycle after that writeback.
- **Pairing block:** A = BR, B = ALU → only A issues. A = ALU, B = MEM → only A issues.
- **Backpressure:** `ex0_ready_i`=0 with `ex0_valid_o`=1 → `deq_cnt_o`=0, `ex0_instr_o` holds, `stall_cnt_o` increments each cycle.
- **Set/clear collision, then flush:** set and clear rd=7 on the same edge → pend[7]=1. Then `flush_i` → valids=0 and scoreboard=0 next cycle; a dependent instruction issues immediately.
- **Saturation and reset:** force 0x10000 stalled cycles → `stall_cnt_o`=0xFFFF. `rst` mid-issue → all outputs 0 the following cycle.
